fp16_accum: RTL and testbench

Accumulates a stream of FP16 (1-5-10, bias 15) products, such as those leaving the FP16 multiplier, into one FP16 sum per vector; it is the adder-tree-free accumulation stage of the convolution datapath. Elements arrive on a valid/ready handshake with an `in_last` tag. Each element passes through a 3-cycle align/add/normalise FSM. When the last element of a vector has been added, the sum and element count are held on the output until the consumer accepts them.

---
 rtl/fp16_accum.sv | 219 +++++++++++++++++++++
 tb/tb_fp16_accum.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fp16_accum.sv
// fp16_accum: accumulates a stream of FP16 (1-5-10, bias 15) values into one
// FP16 sum per vector. Each element runs through a three-state align/add/
// normalise sequence. No denormals, Inf or NaN, and no rounding (truncation only).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data/in_last valid
//   in_ready   element can be accepted (IDLE and not in reset)
//   in_data    FP16 operand
//   in_last    marks final element of the vector
//   out_valid  out_data/out_count valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_data   FP16 vector sum
//   out_count  elements accepted in the vector, modulo 2^CNT_W
module fp16_accum #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {StIdle, StAlign, StNorm, StDone} state_e;

    state_e r_state;
    state_e w_state_next;

    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_elem;
    logic             r_last;
    logic             r_big_sign;
    logic             r_sub;
    logic [4:0]       r_big_exp;
    logic [10:0]      r_big_man;
    logic [10:0]      r_sml_man;
    logic [15:0]      r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_valid;

    logic w_accept;

    assign in_ready  = (r_state == StIdle) && rst_n;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    // ------------------------------------------------------------------
    // Align: pick larger magnitude, shift the smaller mantissa down
    // ------------------------------------------------------------------
    logic [14:0] w_acc_mag;
    logic [14:0] w_elem_mag;
    logic        w_acc_big;
    logic [14:0] w_big_mag;
    logic [14:0] w_sml_mag;
    logic        w_big_sign;
    logic        w_sml_sign;
    logic [10:0] w_big_man;
    logic [10:0] w_sml_man_raw;
    logic [4:0]  w_exp_diff;
    logic [10:0] w_sml_shift;

    // A zero exponent field means exact zero whatever the mantissa holds.
    assign w_acc_mag  = (r_acc[14:10] == 5'd0) ? 15'd0 : r_acc[14:0];
    assign w_elem_mag = (r_elem[14:10] == 5'd0) ? 15'd0 : r_elem[14:0];
    assign w_acc_big  = (w_acc_mag >= w_elem_mag);
    assign w_big_mag  = w_acc_big ? w_acc_mag : w_elem_mag;
    assign w_sml_mag  = w_acc_big ? w_elem_mag : w_acc_mag;
    assign w_big_sign = w_acc_big ? r_acc[15] : r_elem[15];
    assign w_sml_sign = w_acc_big ? r_elem[15] : r_acc[15];

    assign w_big_man     = (w_big_mag[14:10] == 5'd0) ? 11'd0 : {1'b1, w_big_mag[9:0]};
    assign w_sml_man_raw = (w_sml_mag[14:10] == 5'd0) ? 11'd0 : {1'b1, w_sml_mag[9:0]};
    assign w_exp_diff    = w_big_mag[14:10] - w_sml_mag[14:10];
    assign w_sml_shift   = (w_exp_diff >= 5'd11) ? 11'd0 : (w_sml_man_raw >> w_exp_diff);

    // ------------------------------------------------------------------
    // Normalise: add or subtract, renormalise, saturate / flush
    // ------------------------------------------------------------------
    logic [11:0] w_sum;
    logic [10:0] w_dif;
    logic [3:0]  w_lz;
    logic        w_zero;
    logic        w_underflow;
    logic [5:0]  w_exp6;
    logic [9:0]  w_man10;
    logic [15:0] w_res;

    assign w_sum = {1'b0, r_big_man} + {1'b0, r_sml_man};
    // Big magnitude >= small, so this never wraps.
    assign w_dif = r_big_man - r_sml_man;

    // Leading-zero count relative to bit 10; highest set bit wins.
    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i <= 10; i++) begin
            if (w_dif[i]) begin
                w_lz = 4'(10 - i);
            end
        end
    end

    always_comb begin
        w_zero      = 1'b0;
        w_underflow = 1'b0;
        w_exp6      = {1'b0, r_big_exp};
        w_man10     = 10'd0;
        if (!r_sub) begin
            w_zero = (w_sum == 12'd0);
            if (w_sum[11]) begin
                w_exp6  = {1'b0, r_big_exp} + 6'd1;
                w_man10 = w_sum[10:1];
            end else begin
                w_man10 = w_sum[9:0];
            end
        end else begin
            w_zero      = (w_dif == 11'd0);
            w_underflow = ({1'b0, r_big_exp} <= {2'b00, w_lz});
            w_exp6      = {1'b0, r_big_exp} - {2'b00, w_lz};
            w_man10     = 10'(w_dif << w_lz);
        end
    end

    always_comb begin
        w_res = 16'h0000;
        if (w_zero || w_underflow) begin
            w_res = 16'h0000;
        end else if (w_exp6 > 6'd30) begin
            w_res = {r_big_sign, 15'h7BFF};
        end else begin
            w_res = {r_big_sign, w_exp6[4:0], w_man10};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StAlign;
            StAlign: w_state_next = StNorm;
            StNorm:  w_state_next = r_last ? StDone : StIdle;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= 16'h0000;
            r_cnt       <= '0;
            r_elem      <= 16'h0000;
            r_last      <= 1'b0;
            r_big_sign  <= 1'b0;
            r_sub       <= 1'b0;
            r_big_exp   <= 5'd0;
            r_big_man   <= 11'd0;
            r_sml_man   <= 11'd0;
            r_out_data  <= 16'h0000;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_elem <= in_data;
                        r_last <= in_last;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                StAlign: begin
                    r_big_sign <= w_big_sign;
                    r_sub      <= w_big_sign ^ w_sml_sign;
                    r_big_exp  <= w_big_mag[14:10];
                    r_big_man  <= w_big_man;
                    r_sml_man  <= w_sml_shift;
                end
                StNorm: begin
                    r_acc <= w_res;
                    if (r_last) begin
                        r_out_data  <= w_res;
                        r_out_count <= r_cnt;
                        r_out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_acc       <= 16'h0000;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accum.sv
// Directed self-checking bench for fp16_accum: reset values, cycle-exact
// handshake timing, arithmetic corner cases, backpressure and counter wrap.
module tb_fp16_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_count;

    int n_cmp  = 0;
    int n_fail = 0;

    fp16_accum #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one element and hold it until the handshake edge has passed.
    task automatic push(input logic [15:0] d, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("push_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for the result, check it, then accept it.
    task automatic take(input string tag, input logic [15:0] d, input logic [7:0] c);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
        chk({tag, "_count"}, {24'd0, out_count}, {24'd0, c});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'h0);
        chk("rst_out_count", {24'd0, out_count}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic sum, cycle exact: handshakes in cycles 0 and 3
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h3C00;
        in_last   = 1'b0;
        chk("b_c0_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_data = 16'h4000;
        in_last = 1'b1;
        chk("b_c1_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("b_c2_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("b_c3_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("b_c4_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("b_c5_ready", {31'd0, in_ready}, 32'd0);
        chk("b_c5_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("b_c6_ready", {31'd0, in_ready}, 32'd0);
        chk("b_c6_valid", {31'd0, out_valid}, 32'd1);
        chk("b_c6_data", {16'd0, out_data}, 32'h4200);
        chk("b_c6_count", {24'd0, out_count}, 32'd2);
        step();
        chk("b_c7_ready", {31'd0, in_ready}, 32'd1);
        chk("b_c7_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Cancellation and zero-exponent input
        push(16'h3C00, 1'b0);
        push(16'hBC00, 1'b1);
        take("cancel", 16'h0000, 8'd1 + 8'd1);
        push(16'h0005, 1'b1);
        take("zexp", 16'h0000, 8'd1);

        // Negative first element against a zero accumulator
        push(16'hC000, 1'b1);
        take("neg1", 16'hC000, 8'd1);

        // Alignment and truncation
        push(16'h3C00, 1'b0);
        push(16'h1400, 1'b1);
        take("align10", 16'h3C01, 8'd2);
        push(16'h3C00, 1'b0);
        push(16'h1000, 1'b1);
        take("align11", 16'h3C00, 8'd2);
        push(16'h3C00, 1'b0);
        push(16'hB800, 1'b1);
        take("lnorm", 16'h3800, 8'd2);

        // Saturation
        push(16'h7B00, 1'b0);
        push(16'h7B00, 1'b1);
        take("satp", 16'h7BFF, 8'd2);
        push(16'hFB00, 1'b0);
        push(16'hFB00, 1'b1);
        take("satn", 16'hFBFF, 8'd2);

        // Backpressure: result held, new element not consumed during DONE
        push(16'h3C00, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) step();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h4000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {16'd0, out_data}, 32'h3C00);
            chk("bp_hold_count", {24'd0, out_count}, 32'd1);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        push(16'h4000, 1'b1);
        take("bp_next", 16'h4000, 8'd1);

        // Reset during NORM of the second element of a 3-element vector
        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_out_data", {16'd0, out_data}, 32'h0);
        chk("mrst_out_count", {24'd0, out_count}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("mrst_rel_ready", {31'd0, in_ready}, 32'd1);
        push(16'h3800, 1'b1);
        take("mrst_next", 16'h3800, 8'd1);

        // Counter wrap: 257 zero elements give count 1
        for (int i = 0; i < 257; i++) begin
            push(16'h0000, (i == 256) ? 1'b1 : 1'b0);
        end
        take("wrap", 16'h0000, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
